// File: rtl/vdc_pkg.sv
// Shared definitions for the VDC CPU port: register indices, port FSM states
// and the VRAM address increment step selected by CR[12:11].
package vdc_pkg;

   localparam logic [4:0] REG_MAWR = 5'd0;
   localparam logic [4:0] REG_MARR = 5'd1;
   localparam logic [4:0] REG_VWR  = 5'd2;  // reads of this index return VRR
   localparam logic [4:0] REG_CR   = 5'd5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WREQ,
      ST_RREQ
   } vdc_state_e;

   function automatic logic [7:0] inc_step(input logic [1:0] sel);
      case (sel)
         2'b00:   return 8'd1;
         2'b01:   return 8'd32;
         2'b10:   return 8'd64;
         default: return 8'd128;
      endcase
   endfunction

endpackage

// File: rtl/vdc_strobe_edge.sv
// Turns the CPU chip-select/strobe levels into one-cycle access events and
// decodes the port select into status / low-half / high-half accesses.
module vdc_strobe_edge #(
   parameter int CPU_W = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       cs_n,
   input  logic       wr_n,
   input  logic       rd_n,
   input  logic [1:0] a,
   output logic       wr_ev,
   output logic       rd_ev,
   output logic       st_sel,
   output logic       lo_sel,
   output logic       hi_sel
);

   logic wr_act, rd_act, wr_act_q, rd_act_q;

   assign wr_act = !cs_n && !wr_n;
   assign rd_act = !cs_n && !rd_n;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_act_q <= 1'b0;
         rd_act_q <= 1'b0;
      end else begin
         wr_act_q <= wr_act;
         rd_act_q <= rd_act;
      end
   end

   // A held strobe stays active, so only its first cycle produces an event.
   assign wr_ev  = wr_act && !wr_act_q;
   assign rd_ev  = rd_act && !rd_act_q;

   assign st_sel = (a == 2'd0);
   assign lo_sel = (a == 2'd2);
   // A 16-bit bus moves the whole word through port 2; port 3 is unused then.
   assign hi_sel = (CPU_W == 16) ? (a == 2'd2) : (a == 2'd3);

endmodule

// File: rtl/vdc_cpu_port.sv
// HuC6270 CPU register port: AR, register file, VRAM data window and the
// single-transaction VRAM request FSM. Optional VDC_READ_PREFETCH_EN prefetches VRR.
module vdc_cpu_port
   import vdc_pkg::*;
#(
   parameter int CPU_W    = 8,
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int NUM_REGS = 20
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              CS_n,
   input  logic              WR_n,
   input  logic              RD_n,
   input  logic [1:0]        A,
   input  logic [CPU_W-1:0]  D_in,
   output logic [CPU_W-1:0]  D_out,
   output logic              BUSY_n,
   output logic [ADDR_W-1:0] vram_addr,
   output logic [DATA_W-1:0] vram_wdata,
   output logic              vram_we,
   output logic              vram_re,
   input  logic              vram_ack,
   input  logic [DATA_W-1:0] vram_rdata,
   output logic [DATA_W-1:0] cr
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int HALF  = DATA_W / 2;

   logic wr_ev, rd_ev, st_sel, lo_sel, hi_sel;

   vdc_strobe_edge #(.CPU_W(CPU_W)) u_edge (
      .clock   (clock),
      .reset_n (reset_n),
      .cs_n    (CS_n),
      .wr_n    (WR_n),
      .rd_n    (RD_n),
      .a       (A),
      .wr_ev   (wr_ev),
      .rd_ev   (rd_ev),
      .st_sel  (st_sel),
      .lo_sel  (lo_sel),
      .hi_sel  (hi_sel)
   );

   vdc_state_e        state_q, state_d;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [4:0]        ar;
   logic [DATA_W-1:0] vrr;
   logic              drop_q, rd_to_dout;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;

   logic              busy, ar_ok, ar_vram;
   logic [IDX_W-1:0]  ar_idx;
   logic [DATA_W-1:0] din_w, cur_word, wr_word, rd_word;
   logic [ADDR_W-1:0] step_a, mawr, marr, mawr_inc, marr_inc;
   logic [CPU_W-1:0]  rd_out, status;
   logic              start_w, start_r, drop_set;

   assign busy     = (state_q != ST_IDLE);
   assign ar_ok    = int'(ar) < NUM_REGS;
   assign ar_idx   = ar[IDX_W-1:0];
   assign ar_vram  = (ar == REG_VWR);
   assign din_w    = DATA_W'(D_in);
   assign cur_word = ar_ok ? regs[ar_idx] : '0;
   assign rd_word  = ar_vram ? vrr : cur_word;
   assign cr       = regs[REG_CR];
   assign step_a   = ADDR_W'(inc_step(cr[12:11]));
   assign mawr     = ADDR_W'(regs[REG_MAWR]);
   assign marr     = ADDR_W'(regs[REG_MARR]);
   assign mawr_inc = mawr + step_a;
   assign marr_inc = marr + step_a;
   assign status   = CPU_W'({busy, drop_q, 5'b0});

   always_comb begin
      wr_word = cur_word;
      if (lo_sel && hi_sel) wr_word = din_w;
      else if (lo_sel)      wr_word = {cur_word[DATA_W-1:HALF], din_w[HALF-1:0]};
      else if (hi_sel)      wr_word = {din_w[HALF-1:0], cur_word[HALF-1:0]};
   end

   always_comb begin
      rd_out = CPU_W'(rd_word[HALF-1:0]);
      if (lo_sel && hi_sel) rd_out = CPU_W'(rd_word);
      else if (hi_sel)      rd_out = CPU_W'(rd_word[DATA_W-1:HALF]);
   end

   // Accesses that would launch a VRAM transaction while one is pending are dropped.
   always_comb begin
      start_w  = 1'b0;
      start_r  = 1'b0;
      drop_set = 1'b0;
      if (wr_ev && hi_sel && ar_vram) begin
         if (busy) drop_set = 1'b1;
         else      start_w  = 1'b1;
      end
`ifdef VDC_READ_PREFETCH_EN
      if ((wr_ev && hi_sel && ar == REG_MARR) || (rd_ev && hi_sel && ar_vram)) begin
`else
      if (rd_ev && lo_sel && ar_vram) begin
`endif
         if (busy) drop_set = 1'b1;
         else      start_r  = 1'b1;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start_w)      state_d = ST_WREQ;
            else if (start_r) state_d = ST_RREQ;
         end
         ST_WREQ, ST_RREQ: if (vram_ack) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   assign BUSY_n     = !busy;
   assign vram_we    = (state_q == ST_WREQ);
   assign vram_re    = (state_q == ST_RREQ);
   assign vram_addr  = req_addr;
   assign vram_wdata = req_wdata;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
         ar         <= '0;
         vrr        <= '0;
         D_out      <= '0;
         drop_q     <= 1'b0;
         rd_to_dout <= 1'b0;
         req_addr   <= '0;
         req_wdata  <= '0;
      end else begin
         // Ack bookkeeping comes first so a same-cycle CPU access takes precedence.
         if (state_q == ST_WREQ && vram_ack) regs[REG_MAWR] <= DATA_W'(mawr_inc);
         if (state_q == ST_RREQ && vram_ack) begin
            vrr <= vram_rdata;
            if (rd_to_dout) begin
               D_out      <= CPU_W'(vram_rdata);
               rd_to_dout <= 1'b0;
            end
         end

         if (wr_ev) begin
            if (st_sel) ar <= D_in[4:0];
            else if ((lo_sel || hi_sel) && ar_ok && !(ar_vram && drop_set))
               regs[ar_idx] <= wr_word;
         end

         if (rd_ev && st_sel) begin
            D_out <= status;
         end else if (rd_ev && (lo_sel || hi_sel) && !drop_set) begin
            D_out <= rd_out;
            if (hi_sel && ar_vram) regs[REG_MARR] <= DATA_W'(marr_inc);
`ifndef VDC_READ_PREFETCH_EN
            if (lo_sel && ar_vram) rd_to_dout <= 1'b1;
`endif
         end

         if (drop_set)              drop_q <= 1'b1;
         else if (rd_ev && st_sel)  drop_q <= 1'b0;

         if (start_w) begin
            req_addr  <= mawr;
            req_wdata <= wr_word;
         end
`ifdef VDC_READ_PREFETCH_EN
         if (start_r) req_addr <= wr_ev ? ADDR_W'(wr_word) : marr_inc;
`else
         if (start_r) req_addr <= marr;
`endif
      end
   end

endmodule

// File: tb/tb_vdc_cpu_port.sv
// Directed bench for vdc_cpu_port (8-bit CPU bus, 16-bit VRAM words).
module tb_vdc_cpu_port;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        CS_n = 1'b1, WR_n = 1'b1, RD_n = 1'b1;
   logic [1:0]  A = 2'd0;
   logic [7:0]  D_in = 8'd0;
   logic [7:0]  D_out;
   logic        BUSY_n;
   logic [15:0] vram_addr, vram_wdata;
   logic        vram_we, vram_re;
   logic        vram_ack = 1'b0;
   logic [15:0] vram_rdata = 16'd0;
   logic [15:0] cr;

   int checks = 0;
   int errors = 0;
   logic [7:0] rv;

   vdc_cpu_port dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .CS_n       (CS_n),
      .WR_n       (WR_n),
      .RD_n       (RD_n),
      .A          (A),
      .D_in       (D_in),
      .D_out      (D_out),
      .BUSY_n     (BUSY_n),
      .vram_addr  (vram_addr),
      .vram_wdata (vram_wdata),
      .vram_we    (vram_we),
      .vram_re    (vram_re),
      .vram_ack   (vram_ack),
      .vram_rdata (vram_rdata),
      .cr         (cr)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [7:0] d);
      CS_n = 1'b0; WR_n = 1'b0; A = a; D_in = d;
      tick();
      CS_n = 1'b1; WR_n = 1'b1;
      tick();
   endtask

   task automatic rd(input logic [1:0] a, output logic [7:0] d);
      CS_n = 1'b0; RD_n = 1'b0; A = a;
      tick();
      d = D_out;
      CS_n = 1'b1; RD_n = 1'b1;
      tick();
   endtask

   task automatic ack_once(input logic [15:0] data);
      vram_rdata = data; vram_ack = 1'b1;
      tick();
      vram_ack = 1'b0;
   endtask

   initial begin
      tick(); tick();
      chk("rst_busy_n", BUSY_n, 1'b1);
      chk("rst_we", vram_we, 1'b0);
      chk("rst_re", vram_re, 1'b0);
      chk("rst_cr", cr, 16'h0000);
      chk("rst_dout", D_out, 8'h00);
      reset_n = 1'b1;
      tick();

      // VWR commit at MAWR=0x1234
      wr(2'd0, 8'h00); wr(2'd2, 8'h34); wr(2'd3, 8'h12);
      wr(2'd0, 8'h02); wr(2'd2, 8'hEF);
      CS_n = 1'b0; WR_n = 1'b0; A = 2'd3; D_in = 8'hBE;
      tick();
      chk("wr_we", vram_we, 1'b1);
      chk("wr_busy_n", BUSY_n, 1'b0);
      chk("wr_addr", vram_addr, 16'h1234);
      chk("wr_wdata", vram_wdata, 16'hBEEF);
      CS_n = 1'b1; WR_n = 1'b1;
      tick();
      wr(2'd3, 8'h55);                     // second commit while pending: dropped
      chk("wr_hold_wdata", vram_wdata, 16'hBEEF);
      rd(2'd0, rv);
      chk("stat_busy_drop", rv, 8'h60);
      chk("wr_still_busy", BUSY_n, 1'b0);
      ack_once(16'h0000);
      chk("wr_done_busy_n", BUSY_n, 1'b1);
      chk("wr_done_we", vram_we, 1'b0);
      rd(2'd0, rv);
      chk("stat_cleared", rv, 8'h00);
      wr(2'd0, 8'h00);
      rd(2'd2, rv); chk("mawr_lo", rv, 8'h35);
      rd(2'd3, rv); chk("mawr_hi", rv, 8'h12);

      // step 128 with wrap
      wr(2'd0, 8'h05); wr(2'd2, 8'h00); wr(2'd3, 8'h18);
      chk("cr_set", cr, 16'h1800);
      wr(2'd0, 8'h00); wr(2'd2, 8'hC0); wr(2'd3, 8'hFF);
      wr(2'd0, 8'h02); wr(2'd2, 8'h11); wr(2'd3, 8'h22);
      chk("wrap_addr", vram_addr, 16'hFFC0);
      chk("wrap_wdata", vram_wdata, 16'h2211);
      ack_once(16'h0000);
      wr(2'd0, 8'h00);
      rd(2'd2, rv); chk("wrap_mawr_lo", rv, 8'h40);
      rd(2'd3, rv); chk("wrap_mawr_hi", rv, 8'h00);
      wr(2'd0, 8'h05); wr(2'd3, 8'h00);
      chk("cr_clear", cr, 16'h0000);

      // VRAM reads through VRR, MARR=0x0010
      wr(2'd0, 8'h01); wr(2'd2, 8'h10);
`ifdef VDC_READ_PREFETCH_EN
      CS_n = 1'b0; WR_n = 1'b0; A = 2'd3; D_in = 8'h00;
      tick();
      chk("pf_re", vram_re, 1'b1);
      chk("pf_addr", vram_addr, 16'h0010);
      CS_n = 1'b1; WR_n = 1'b1;
      ack_once(16'hA55A);
      wr(2'd0, 8'h02);
      rd(2'd2, rv); chk("pf_vrr_lo", rv, 8'h5A);
      chk("pf_no_re", vram_re, 1'b0);
      CS_n = 1'b0; RD_n = 1'b0; A = 2'd3;
      tick();
      chk("pf_vrr_hi", D_out, 8'hA5);
      chk("pf_re2", vram_re, 1'b1);
      chk("pf_addr2", vram_addr, 16'h0011);
      CS_n = 1'b1; RD_n = 1'b1;
      ack_once(16'h1234);
      rd(2'd2, rv); chk("pf_vrr_lo2", rv, 8'h34);
`else
      wr(2'd3, 8'h00);
      chk("np_no_re", vram_re, 1'b0);
      chk("np_idle", BUSY_n, 1'b1);
      wr(2'd0, 8'h02);
      CS_n = 1'b0; RD_n = 1'b0; A = 2'd2;
      tick();
      chk("np_re", vram_re, 1'b1);
      chk("np_addr", vram_addr, 16'h0010);
      chk("np_busy_n", BUSY_n, 1'b0);
      CS_n = 1'b1; RD_n = 1'b1;
      ack_once(16'hA55A);
      chk("np_vrr_lo", D_out, 8'h5A);
      chk("np_done", BUSY_n, 1'b1);
      rd(2'd3, rv); chk("np_vrr_hi", rv, 8'hA5);
      chk("np_hi_no_re", vram_re, 1'b0);
      CS_n = 1'b0; RD_n = 1'b0; A = 2'd2;
      tick();
      chk("np_addr2", vram_addr, 16'h0011);
      chk("np_re2", vram_re, 1'b1);
      CS_n = 1'b1; RD_n = 1'b1;
      ack_once(16'h1234);
      chk("np_vrr_lo2", D_out, 8'h34);
`endif

      // held strobe: exactly one AR update
      wr(2'd0, 8'h03); wr(2'd2, 8'h33);
      wr(2'd0, 8'h04); wr(2'd2, 8'h44);
      CS_n = 1'b0; WR_n = 1'b0; A = 2'd0; D_in = 8'h03;
      tick();
      D_in = 8'h04;
      repeat (4) tick();
      CS_n = 1'b1; WR_n = 1'b1;
      tick();
      rd(2'd2, rv); chk("hold_one_ar", rv, 8'h33);

      // reset in the middle of a write request
      wr(2'd0, 8'h05); wr(2'd2, 8'h01);
      chk("cr_pre_rst", cr, 16'h0001);
      wr(2'd0, 8'h02); wr(2'd3, 8'h99);
      chk("pre_rst_we", vram_we, 1'b1);
      wr(2'd3, 8'h77);
      reset_n = 1'b0;
      tick();
      chk("mid_rst_we", vram_we, 1'b0);
      chk("mid_rst_re", vram_re, 1'b0);
      chk("mid_rst_busy_n", BUSY_n, 1'b1);
      chk("mid_rst_cr", cr, 16'h0000);
      chk("mid_rst_dout", D_out, 8'h00);
      reset_n = 1'b1;
      tick();
      rd(2'd0, rv); chk("post_rst_stat", rv, 8'h00);
      rd(2'd2, rv); chk("post_rst_mawr", rv, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
